// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension issue logic: FSM state encoding,
// RISC-V M funct3 codes and default widths.
package muldiv_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int REGADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    // DIV/DIVU/REM/REMU occupy the upper half of the funct3 space.
    function automatic logic f3_is_div(input logic [2:0] funct3);
        return funct3 >= F3_DIV;
    endfunction

endpackage

// File: rtl/muldiv_reuse_cache.sv
// One-entry result cache for muldiv_issue; only present when MULDIV_REUSE_EN
// is defined. Stores {valid, funct3, rs1, rs2, result} and flags exact matches.
`ifdef MULDIV_REUSE_EN
module muldiv_reuse_cache
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            write_en,
    input  logic [2:0]      wr_funct3,
    input  logic [XLEN-1:0] wr_rs1,
    input  logic [XLEN-1:0] wr_rs2,
    input  logic [XLEN-1:0] wr_result,
    input  logic [2:0]      lk_funct3,
    input  logic [XLEN-1:0] lk_rs1,
    input  logic [XLEN-1:0] lk_rs2,
    output logic            hit,
    output logic [XLEN-1:0] hit_data
);

    logic            valid_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] rs1_reg;
    logic [XLEN-1:0] rs2_reg;
    logic [XLEN-1:0] result_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg  <= 1'b0;
            funct3_reg <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            result_reg <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (write_en) begin
            valid_reg  <= 1'b1;
            funct3_reg <= wr_funct3;
            rs1_reg    <= wr_rs1;
            rs2_reg    <= wr_rs2;
            result_reg <= wr_result;
        end
    end

    assign hit      = valid_reg && (lk_funct3 == funct3_reg)
                      && (lk_rs1 == rs1_reg) && (lk_rs2 == rs2_reg);
    assign hit_data = result_reg;

endmodule
`endif

// File: rtl/muldiv_issue.sv
// Core-side initiator for the multiply/divide unit: latches one op from EX,
// holds the unit request until done and returns a one-cycle writeback pulse.
// Optional result reuse cache is enabled by defining MULDIV_REUSE_EN.
module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int REGADDR_W = REGADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_rs1,
    input  logic [XLEN-1:0]      req_rs2,
    input  logic [REGADDR_W-1:0] req_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic                 wb_valid,
    output logic [REGADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 md_start,
    output logic [XLEN-1:0]      md_in_A,
    output logic [XLEN-1:0]      md_in_B,
    output logic [1:0]           md_op_mul,
    output logic [1:0]           md_op_div,
    output logic                 md_sel,
    input  logic [XLEN-1:0]      md_R,
    input  logic                 md_done
);

    state_t                 state_reg;
    logic [2:0]             op_funct3_reg;
    logic [XLEN-1:0]        op_rs1_reg;
    logic [XLEN-1:0]        op_rs2_reg;
    logic [REGADDR_W-1:0]   op_rd_reg;
    logic                   md_start_reg;
    logic                   wb_valid_reg;
    logic [REGADDR_W-1:0]   wb_rd_reg;
    logic [XLEN-1:0]        wb_data_reg;

    logic                   accept;
    logic                   drain_entry;
    logic                   reuse_hit;
    logic [XLEN-1:0]        reuse_data;
    logic                   op_is_div;
    logic                   stall_next;

    assign accept      = (state_reg == IDLE) && req_valid && !flush;
    assign drain_entry = (state_reg == BUSY) && flush && !md_done;

`ifdef MULDIV_REUSE_EN
    muldiv_reuse_cache #(
        .XLEN (XLEN)
    ) u_reuse_cache (
        .clk       (clk),
        .reset     (reset),
        .clear     (drain_entry),
        .write_en  (state_reg == RESP),
        .wr_funct3 (op_funct3_reg),
        .wr_rs1    (op_rs1_reg),
        .wr_rs2    (op_rs2_reg),
        .wr_result (wb_data_reg),
        .lk_funct3 (req_funct3),
        .lk_rs1    (req_rs1),
        .lk_rs2    (req_rs2),
        .hit       (reuse_hit),
        .hit_data  (reuse_data)
    );
`else
    assign reuse_hit  = 1'b0;
    assign reuse_data = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            op_funct3_reg <= '0;
            op_rs1_reg    <= '0;
            op_rs2_reg    <= '0;
            op_rd_reg     <= '0;
            md_start_reg  <= 1'b0;
            wb_valid_reg  <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
        end else begin
            wb_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_funct3_reg <= req_funct3;
                        op_rs1_reg    <= req_rs1;
                        op_rs2_reg    <= req_rs2;
                        op_rd_reg     <= req_rd;
                        if (reuse_hit) begin
                            state_reg    <= RESP;
                            wb_valid_reg <= 1'b1;
                            wb_rd_reg    <= req_rd;
                            wb_data_reg  <= reuse_data;
                        end else begin
                            state_reg    <= BUSY;
                            md_start_reg <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // A flush always wins over a coincident done.
                    if (flush) begin
                        if (md_done) begin
                            state_reg    <= IDLE;
                            md_start_reg <= 1'b0;
                        end else begin
                            state_reg <= DRAIN;
                        end
                    end else if (md_done) begin
                        state_reg    <= RESP;
                        md_start_reg <= 1'b0;
                        wb_valid_reg <= 1'b1;
                        wb_rd_reg    <= op_rd_reg;
                        wb_data_reg  <= md_R;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                DRAIN: begin
                    if (md_done) begin
                        state_reg    <= IDLE;
                        md_start_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    md_start_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_next = 1'b0;
        case (state_reg)
            IDLE:    stall_next = req_valid && !flush;
            BUSY:    stall_next = 1'b1;
            RESP:    stall_next = 1'b0;
            DRAIN:   stall_next = req_valid;
            default: stall_next = 1'b0;
        endcase
    end

    // Gate with reset so every output reads zero while reset is held.
    assign stall     = reset && stall_next;

    assign op_is_div = f3_is_div(op_funct3_reg);
    assign md_sel    = op_is_div;
    assign md_op_mul = op_is_div ? 2'b00 : op_funct3_reg[1:0];
    assign md_op_div = op_is_div ? op_funct3_reg[1:0] : 2'b00;
    assign md_in_A   = op_rs1_reg;
    assign md_in_B   = op_rs2_reg;
    assign md_start  = md_start_reg;

    assign wb_valid  = wb_valid_reg;
    assign wb_rd     = wb_rd_reg;
    assign wb_data   = wb_data_reg;

endmodule
